hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage CPU: the driver side of every pipeline register's stall/flush inputs (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). Detects load-use hazards, taken branches and data-memory wait states, and sequences a post-reset pipeline purge. Its FSM also watches for memory hangs and keeps saturating stall/flush performance counters.

## Interface
- FLUSH_CYCLES, 5: cycles of forced pipeline purge after rst deasserts (≥1)
- TIMEOUT, 64: consecutive memory-busy cycles tolerated before fatal timeout (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- ifid_rs1, ifid_rs2  in  5 each  source registers of instruction in ID
- ifid_use_rs1, ifid_use_rs2  in  1 each  ID instruction actually reads rs1/rs2
- idex_memread  in  1  EX instruction is a load
- idex_rd  in  5  destination of EX instruction
- ex_branch_taken  in  1  EX resolved a taken branch/jump
- exmem_memaccess  in  1  MEM instruction is a load or store
- dmem_ready  in  1  data memory completes access this cycle
- pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall  out  1 each  hold stage
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  bubble stage
- mem_timeout  out  1  sticky fatal error
- stall_cycles  out  16  saturating count of stalled cycles
- flush_events  out  16  saturating count of branch flushes

## Operation
- Derived: mem_busy = exmem_memaccess & ~dmem_ready; load_use = idex_memread & idex_rd≠0 & ((ifid_use_rs1 & ifid_rs1==idex_rd) | (ifid_use_rs2 & ifid_rs2==idex_rd)).
- FSM states: PURGE, RUN, MEM_WAIT, TIMEOUT. Control outputs are combinational from state and inputs; state and counters are registered.
- rst=1 at a clock edge: state←PURGE, purge_cnt←0, wait_cnt←0, stall_cycles←0, flush_events←0, and mem_timeout clears.
- PURGE: pc_stall=1, all four flushes=1, other stalls=0. purge_cnt increments each non-reset cycle. Go to RUN after FLUSH_CYCLES cycles.
- RUN and MEM_WAIT use the same output priority: mem_busy > ex_branch_taken > load_use > none.
  - mem_busy: pc/ifid/idex/exmem_stall=1 and memwb_flush=1. The pending branch or load-use is re-evaluated after release.
  - branch: ifid_flush=idex_flush=1. flush_events+1. This overrides load_use because the hazarding ID instruction is being squashed.
  - load_use: pc_stall=ifid_stall=1 and idex_flush=1.
  - none: all stall/flush outputs 0.
- Transitions:
  - RUN→MEM_WAIT when mem_busy.
  - MEM_WAIT→RUN when ~mem_busy.
  - MEM_WAIT→TIMEOUT when mem_busy and wait_cnt==TIMEOUT-1.
- wait_cnt counts consecutive mem_busy cycles (first busy cycle in RUN counts as 1). It clears whenever ~mem_busy.
- TIMEOUT: all five stalls=1, all flushes=0, mem_timeout=1. Only rst exits.
- Invariant: a stage never sees stall and flush asserted together.
- stall_cycles increments on any cycle with pc_stall=1 in RUN or MEM_WAIT (not PURGE/TIMEOUT). It saturates at 0xFFFF; flush_events likewise.

## Timing
- Hazard outputs have zero latency: they are asserted in the same cycle as the causing inputs, and pipeline registers act on the next edge.
- Load-use costs exactly 1 stall cycle, provided the load advances normally.
- Memory wait of N busy cycles gives N stall cycles. Outputs drop in the cycle dmem_ready=1.
- After rst falls: FLUSH_CYCLES cycles of PURGE, then RUN outputs.
- rst during MEM_WAIT or TIMEOUT: next cycle is PURGE with counters and error cleared.
- mem_busy arriving in the same cycle as a branch or load-use: mem_busy outputs only, and flush_events does not increment.

## Test plan
- Reset release, FLUSH_CYCLES=5 → 5 cycles of pc_stall=1 with all flushes=1, then all outputs 0. mem_timeout=0, counters=0.
- idex_memread=1, idex_rd=5, ifid_rs2=5, ifid_use_rs2=1 for one cycle → that cycle pc_stall=ifid_stall=idex_flush=1, stall_cycles=1. Repeat with idex_rd=0 → no stall.
- ex_branch_taken=1 with load_use also true → ifid_flush=idex_flush=1, pc_stall=0, flush_events=1.
- exmem_memaccess=1, dmem_ready low for 3 cycles then high → 3 cycles of pc/ifid/idex/exmem_stall=1 and memwb_flush=1, then clear. stall_cycles=3.
- TIMEOUT=4, dmem_ready held low → after 4 busy cycles state TIMEOUT: all stalls=1, mem_timeout=1. Setting dmem_ready=1 keeps it stuck; rst pulse returns to PURGE with mem_timeout=0.
- Force 70000 load-use cycles → stall_cycles saturates at 0xFFFF, no wrap.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller driving stall/flush of every pipeline register
//
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   ifid_rs1/rs2, ifid_use_rs1/2  source registers of the ID instruction and whether it reads them
//   idex_memread, idex_rd         EX instruction is a load, and its destination register
//   ex_branch_taken               EX resolved a taken branch/jump
//   exmem_memaccess, dmem_ready   MEM instruction accesses memory / memory completes this cycle
//   *_stall                       hold the named pipeline register (pc, ifid, idex, exmem, memwb)
//   *_flush                       insert a bubble into the named pipeline register
//   mem_timeout                   sticky fatal error after TIMEOUT consecutive busy cycles
//   stall_cycles, flush_events    saturating performance counters
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 5,
    parameter int TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ifid_rs1,
    input  logic [4:0]  ifid_rs2,
    input  logic        ifid_use_rs1,
    input  logic        ifid_use_rs2,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rd,
    input  logic        ex_branch_taken,
    input  logic        exmem_memaccess,
    input  logic        dmem_ready,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        idex_stall,
    output logic        exmem_stall,
    output logic        memwb_stall,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        memwb_flush,
    output logic        mem_timeout,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_events
);

    localparam int PW = $clog2(FLUSH_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] PURGE_LAST = PW'(FLUSH_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_PURGE,
        S_RUN,
        S_MEM_WAIT,
        S_TIMEOUT
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] purge_cnt_q, purge_cnt_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [15:0]   stall_cycles_q, stall_cycles_d;
    logic [15:0]   flush_events_q, flush_events_d;

    logic mem_busy;
    logic load_use;

    assign mem_busy = exmem_memaccess & ~dmem_ready;
    assign load_use = idex_memread & (idex_rd != 5'd0) &
                      ((ifid_use_rs1 & (ifid_rs1 == idex_rd)) |
                       (ifid_use_rs2 & (ifid_rs2 == idex_rd)));

    always_comb begin
        pc_stall       = 1'b0;
        ifid_stall     = 1'b0;
        idex_stall     = 1'b0;
        exmem_stall    = 1'b0;
        memwb_stall    = 1'b0;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        exmem_flush    = 1'b0;
        memwb_flush    = 1'b0;
        mem_timeout    = 1'b0;
        state_d        = state_q;
        purge_cnt_d    = purge_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;

        case (state_q)
            S_PURGE: begin
                // Hold fetch and bubble everything downstream until the pipe is clean.
                pc_stall    = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                memwb_flush = 1'b1;
                purge_cnt_d = purge_cnt_q + 1'b1;
                if (purge_cnt_q == PURGE_LAST) begin
                    state_d = S_RUN;
                end
            end

            S_RUN, S_MEM_WAIT: begin
                if (mem_busy) begin
                    // Freeze everything up to MEM; WB receives a bubble. Any branch or
                    // load-use seen now is simply re-evaluated once memory releases.
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_stall  = 1'b1;
                    exmem_stall = 1'b1;
                    memwb_flush = 1'b1;
                    wait_cnt_d  = wait_cnt_q + 1'b1;
                    if (state_q == S_RUN) begin
                        state_d = S_MEM_WAIT;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_d = S_TIMEOUT;
                    end
                end else begin
                    wait_cnt_d = '0;
                    state_d    = S_RUN;
                    if (ex_branch_taken) begin
                        // Branch wins over load-use: the hazarding ID instruction is squashed.
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        if (flush_events_q != 16'hFFFF) begin
                            flush_events_d = flush_events_q + 16'd1;
                        end
                    end else if (load_use) begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_flush = 1'b1;
                    end
                end
                if (pc_stall && (stall_cycles_q != 16'hFFFF)) begin
                    stall_cycles_d = stall_cycles_q + 16'd1;
                end
            end

            S_TIMEOUT: begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_stall  = 1'b1;
                exmem_stall = 1'b1;
                memwb_stall = 1'b1;
                mem_timeout = 1'b1;
            end

            default: begin
                state_d = S_PURGE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_PURGE;
            purge_cnt_q    <= '0;
            wait_cnt_q     <= '0;
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            state_q        <= state_d;
            purge_cnt_q    <= purge_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  ifid_rs1 = '0, ifid_rs2 = '0, idex_rd = '0;
    logic        ifid_use_rs1 = 1'b0, ifid_use_rs2 = 1'b0, idex_memread = 1'b0;
    logic        ex_branch_taken = 1'b0, exmem_memaccess = 1'b0, dmem_ready = 1'b1;
    logic        pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall;
    logic        ifid_flush, idex_flush, exmem_flush, memwb_flush, mem_timeout;
    logic [15:0] stall_cycles, flush_events;

    // {pc,ifid,idex,exmem,memwb stall | ifid,idex,exmem,memwb flush | mem_timeout}
    localparam logic [9:0] O_NONE  = 10'b00000_0000_0;
    localparam logic [9:0] O_PURGE = 10'b10000_1111_0;
    localparam logic [9:0] O_LU    = 10'b11000_0100_0;
    localparam logic [9:0] O_BR    = 10'b00000_1100_0;
    localparam logic [9:0] O_MB    = 10'b11110_0001_0;
    localparam logic [9:0] O_TO    = 10'b11111_0000_1;

    typedef struct {
        string       name;
        logic [9:0]  o;
        logic [15:0] sc;
        logic [15:0] fe;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    hazard_ctrl #(.FLUSH_CYCLES(5), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
        .idex_memread(idex_memread), .idex_rd(idex_rd),
        .ex_branch_taken(ex_branch_taken),
        .exmem_memaccess(exmem_memaccess), .dmem_ready(dmem_ready),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
        .exmem_stall(exmem_stall), .memwb_stall(memwb_stall),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs just after the edge; optionally queue the expected response.
    task automatic step(input string name, input logic r, input logic mr, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                        input logic br, input logic ma, input logic rdy,
                        input logic [9:0] eo, input logic [15:0] sc, input logic [15:0] fe,
                        input bit push);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; idex_memread = mr; idex_rd = rd;
        ifid_rs1 = rs1; ifid_use_rs1 = u1; ifid_rs2 = rs2; ifid_use_rs2 = u2;
        ex_branch_taken = br; exmem_memaccess = ma; dmem_ready = rdy;
        if (push) begin
            e.name = name; e.o = eo; e.sc = sc; e.fe = fe;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: outputs are presented every cycle, compare mid-cycle.
    initial begin
        exp_t e;
        logic [9:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = {pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall,
                       ifid_flush, idex_flush, exmem_flush, memwb_flush, mem_timeout};
                checks++;
                if (act !== e.o) begin
                    errors++;
                    $display("FAIL %s outputs: got %b expected %b", e.name, act, e.o);
                end
                checks++;
                if (stall_cycles !== e.sc) begin
                    errors++;
                    $display("FAIL %s stall_cycles: got %h expected %h", e.name, stall_cycles, e.sc);
                end
                checks++;
                if (flush_events !== e.fe) begin
                    errors++;
                    $display("FAIL %s flush_events: got %h expected %h", e.name, flush_events, e.fe);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and purge
        step("rst_hold", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_PURGE, 0, 0, 1);
        for (int i = 0; i < 5; i++)
            step("purge", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_PURGE, 0, 0, 1);
        step("run_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_NONE, 0, 0, 1);

        // Load-use on rs2, then same with rd=0
        step("lu_rs2", 0, 1, 5, 0, 0, 5, 1, 0, 0, 1, O_LU, 0, 0, 1);
        step("lu_rd0", 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, O_NONE, 1, 0, 1);
        // Load-use on rs1, then rs1 match but not read
        step("lu_rs1", 0, 1, 7, 7, 1, 0, 0, 0, 0, 1, O_LU, 1, 0, 1);
        step("lu_nouse", 0, 1, 7, 7, 0, 0, 0, 0, 0, 1, O_NONE, 2, 0, 1);

        // Branch overrides load-use
        step("br_lu", 0, 1, 3, 3, 1, 0, 0, 1, 0, 1, O_BR, 2, 0, 1);
        step("after_br", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_NONE, 2, 1, 1);

        // Memory wait of 3 busy cycles; first busy cycle also has a branch
        step("mb1_br", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, O_MB, 2, 1, 1);
        step("mb2", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_MB, 3, 1, 1);
        step("mb3", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_MB, 4, 1, 1);
        step("mb_rel_br", 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, O_BR, 5, 1, 1);
        step("after_mb", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_NONE, 5, 2, 1);

        // Timeout after 4 consecutive busy cycles
        step("to_b1", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_MB, 5, 2, 1);
        step("to_b2", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_MB, 6, 2, 1);
        step("to_b3", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_MB, 7, 2, 1);
        step("to_b4", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_MB, 8, 2, 1);
        step("to_state", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_TO, 9, 2, 1);
        step("to_stuck", 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, O_TO, 9, 2, 1);
        step("to_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_TO, 9, 2, 1);
        for (int i = 0; i < 5; i++)
            step("repurge", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_PURGE, 0, 0, 1);
        step("rerun_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_NONE, 0, 0, 1);

        // Saturation: 70000 load-use cycles
        step("sat_first", 0, 1, 9, 0, 0, 9, 1, 0, 0, 1, O_LU, 0, 0, 1);
        for (int i = 1; i < 70000; i++)
            step("sat", 0, 1, 9, 0, 0, 9, 1, 0, 0, 1, O_LU, 0, 0, 0);
        step("sat_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_NONE, 16'hFFFF, 0, 1);
        step("sat_more", 0, 1, 9, 0, 0, 9, 1, 0, 0, 1, O_LU, 16'hFFFF, 0, 1);
        step("sat_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_NONE, 16'hFFFF, 0, 1);

        @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
